mux_scan_ctrl: RTL and testbench
================================

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter K, default 64, meaning number of mux channels scanned (2..64).
REQ-002 SHALL have parameter SETTLE, default 1, meaning extra cycles sel is held before sampling (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request a scan; sampled only in IDLE.
REQ-006 SHALL have port en_mask  input  K  channel enable mask, captured on the accepted start.
REQ-007 SHALL have port sel  output  6  select driven to the downstream Kx1 mux s input.
REQ-008 SHALL have port mux_y  input  1  mux output y for the current sel.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until the snapshot is handed off.
REQ-010 SHALL have port snap  output  K  assembled snapshot; bit j = sampled mux_y of channel j, 0 if disabled.
REQ-011 SHALL have port ones  output  7  count of 1s in snap.
REQ-012 SHALL have port snap_valid  output  1  snapshot available.
REQ-013 SHALL have port snap_ready  input  1  consumer accepts snapshot when high with snap_valid.

Function
REQ-014 SHALL implement states IDLE, SELECT, HOLD.
REQ-015 IDLE: start=1 SHALL capture en_mask, clear snap and ones, and go to SELECT at the lowest enabled index; mask all-zero SHALL go directly to HOLD with snap=0, ones=0.
REQ-016 SELECT: sel SHALL equal the current index, held for exactly SETTLE+1 cycles; mux_y SHALL be sampled on the last of those cycles into snap[index], and ones incremented if mux_y=1.
REQ-017 After sampling, the index SHALL advance to the next higher enabled index in the same cycle; disabled channels consume zero cycles.
REQ-018 After sampling the highest enabled index, the FSM SHALL go to HOLD; snap_valid SHALL rise the next cycle.
REQ-019 Scan latency SHALL be N*(SETTLE+1) cycles from the accepted start to entering HOLD, where N = enabled channel count.
REQ-020 HOLD: snap, ones and snap_valid SHALL stay stable until snap_valid&snap_ready; that handshake cycle returns to IDLE, snap_valid and busy fall next cycle, and snap/ones retain their values.
REQ-021 start SHALL be ignored outside IDLE; en_mask changes after capture SHALL have no effect.
REQ-022 sel SHALL be 0 in IDLE and HOLD; indices SHALL never exceed K-1, and sel SHALL be zero-extended to 6 bits.
REQ-023 ones SHALL saturate-free count to at most K (7 bits suffice for K=64).

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, sel=0, snap=0, ones=0, snap_valid=0, busy=0, captured mask=0, settle counter=0.
REQ-025 Reset asserted mid-scan or in HOLD SHALL abandon the snapshot; no snap_valid pulse follows release.

Structure
REQ-026 A shared package SHALL hold the state enumeration, SEL_W=6, and the ones-width constant.
REQ-027 One sub-module, scan_next_idx, SHALL compute the next enabled index above a given index plus a "none" flag (combinational priority finder).

Verification
REQ-028 K=8, SETTLE=1, mask=8'hFF, mux model y=i[sel] with i=8'hA5 -> snap=8'hA5, ones=4, snap_valid 16 cycles after start accepted+1.
REQ-029 K=8, SETTLE=0, mask=8'h81, i=8'hFF -> sel visits 0 then 7 only, snap=8'h81, ones=2, HOLD after 2 cycles.
REQ-030 mask=0, start=1 -> snap_valid next+1 cycle, snap=0, ones=0, sel stays 0.
REQ-031 snap_ready held low 10 cycles in HOLD -> snap/ones/snap_valid stable throughout; start pulses during scan and HOLD ignored.
REQ-032 rst_n pulled low mid-scan at channel 3 -> all outputs 0 immediately, no snap_valid after release; new start completes normally.
REQ-033 K=64, SETTLE=2, mask=all-ones, i=64'h8000_0000_0000_0001 -> sel reaches 63, snap equals i, ones=2, latency 192 cycles.

Source files
------------

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and widths for the mux scan controller.
package mux_scan_ctrl_pkg;

  localparam int unsigned SEL_W  = 6;
  localparam int unsigned ONES_W = 7;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational priority finder: lowest enabled channel above base
// (or at base when incl is set), with a flag when none remain.
module scan_next_idx
  import mux_scan_ctrl_pkg::*;
#(
  parameter int K = 64
) (
  input  logic [K-1:0]     mask,
  input  logic [SEL_W-1:0] base,
  input  logic             incl,
  output logic [SEL_W-1:0] nxt,
  output logic             none
);

  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int j = 0; j < K; j++) begin
      if (none && mask[j] && ((j > int'(base)) || (incl && (j == int'(base))))) begin
        nxt  = SEL_W'(j);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of an external Kx1 mux, assembles a snapshot
// with a ones count, and hands it off over a valid/ready handshake.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int K      = 64,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K-1:0]      en_mask,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic              busy,
  output logic [K-1:0]      snap,
  output logic [ONES_W-1:0] ones,
  output logic              snap_valid,
  input  logic              snap_ready
);

  state_t             state_q, state_d;
  logic [K-1:0]       mask_q, mask_d, snap_d, find_mask;
  logic [SEL_W-1:0]   sel_d, find_base, nxt_c;
  logic [ONES_W-1:0]  ones_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, valid_d, find_incl, none_c;
  logic               sample_c, handoff_c;

  assign sample_c  = (state_q == SELECT) && (cnt_q == CNT_W'(SETTLE));
  assign handoff_c = (state_q == HOLD) && snap_valid && snap_ready;

  // In IDLE search the incoming mask from 0; while scanning, search above sel.
  always_comb begin
    find_mask = mask_q;
    find_base = sel;
    find_incl = 1'b0;
    if (state_q == IDLE) begin
      find_mask = en_mask;
      find_base = '0;
      find_incl = 1'b1;
    end
  end

  scan_next_idx #(.K(K)) u_next (
    .mask (find_mask),
    .base (find_base),
    .incl (find_incl),
    .nxt  (nxt_c),
    .none (none_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = none_c ? HOLD : SELECT;
      SELECT:  if (sample_c && none_c) state_d = HOLD;
      HOLD:    if (handoff_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath.
  always_comb begin
    mask_d  = mask_q;
    snap_d  = snap;
    ones_d  = ones;
    sel_d   = sel;
    cnt_d   = cnt_q;
    busy_d  = busy;
    valid_d = snap_valid;
    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = en_mask;
          snap_d = '0;
          ones_d = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          sel_d  = none_c ? '0 : nxt_c;
        end
      end
      SELECT: begin
        if (sample_c) begin
          snap_d = snap | (K'(mux_y) << sel);
          ones_d = ones + ONES_W'(mux_y);
          cnt_d  = '0;
          sel_d  = none_c ? '0 : nxt_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (handoff_c) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      snap       <= '0;
      ones       <= '0;
      sel        <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      snap       <= snap_d;
      ones       <= ones_d;
      sel        <= sel_d;
      cnt_q      <= cnt_d;
      busy       <= busy_d;
      snap_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed and randomized scans of mux_scan_ctrl against a queue-based
// reference of the enabled-channel visit order and snapshot contents.
module tb_mux_scan_ctrl;
  import mux_scan_ctrl_pkg::*;

  localparam int K      = 64;
  localparam int SETTLE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              snap_ready = 1'b0;
  logic [K-1:0]      en_mask = '0;
  logic [K-1:0]      pat = '0;
  logic              mux_y, busy, snap_valid;
  logic [K-1:0]      snap;
  logic [SEL_W-1:0]  sel;
  logic [ONES_W-1:0] ones;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural mux: y = i[sel]
  assign mux_y = pat[sel];

  mux_scan_ctrl #(.K(K), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .en_mask    (en_mask),
    .sel        (sel),
    .mux_y      (mux_y),
    .busy       (busy),
    .snap       (snap),
    .ones       (ones),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   64'(sel), 64'd0);
    chk({tag, "_snap"},  64'(snap), 64'd0);
    chk({tag, "_ones"},  64'(ones), 64'd0);
    chk({tag, "_valid"}, 64'(snap_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  // One full scan: visit order, latency, HOLD stability, handoff.
  task automatic run_scan(input logic [K-1:0] m, input logic [K-1:0] p,
                          input int hold_cycles, input bit noise);
    int idx_q[$];
    int lat;
    logic [K-1:0] exp_snap;
    logic [ONES_W-1:0] exp_ones;
    for (int j = 0; j < K; j++) if (m[j]) idx_q.push_back(j);
    lat      = idx_q.size() * (SETTLE + 1);
    exp_snap = m & p;
    exp_ones = ONES_W'($countones(exp_snap));

    @(negedge clk);
    pat = p; en_mask = m; start = 1'b1;
    for (int t = 0; t <= lat + 1; t++) begin
      @(negedge clk);
      if (t < lat) begin
        chk("scan_sel", 64'(sel), 64'(idx_q[t / (SETTLE + 1)]));
        chk("scan_valid", 64'(snap_valid), 64'd0);
        chk("scan_busy", 64'(busy), 64'd1);
        if (t == 0) chk("snap_cleared", 64'(snap), 64'd0);
      end else if (t == lat) begin
        chk("hold_entry_sel", 64'(sel), 64'd0);
        chk("hold_entry_valid", 64'(snap_valid), 64'd0);
        chk("hold_entry_busy", 64'(busy), 64'd1);
        chk("hold_entry_snap", 64'(snap), 64'(exp_snap));
        chk("hold_entry_ones", 64'(ones), 64'(exp_ones));
      end else begin
        chk("valid_rise", 64'(snap_valid), 64'd1);
        chk("valid_snap", 64'(snap), 64'(exp_snap));
        chk("valid_ones", 64'(ones), 64'(exp_ones));
        chk("valid_sel", 64'(sel), 64'd0);
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) en_mask = {$urandom, $urandom};
    end

    snap_ready = 1'b0;
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(snap_valid), 64'd1);
      chk("hold_snap", 64'(snap), 64'(exp_snap));
      chk("hold_ones", 64'(ones), 64'(exp_ones));
      chk("hold_busy", 64'(busy), 64'd1);
      chk("hold_sel", 64'(sel), 64'd0);
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    start = 1'b0;
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    chk("handoff_valid", 64'(snap_valid), 64'd0);
    chk("handoff_busy", 64'(busy), 64'd0);
    chk("handoff_snap", 64'(snap), 64'(exp_snap));
    chk("handoff_ones", 64'(ones), 64'(exp_ones));
    chk("handoff_sel", 64'(sel), 64'd0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    // Full low byte, pattern A5
    run_scan(64'hFF, 64'hA5, 2, 1'b0);
    // Only channels 0 and 7
    run_scan(64'h81, 64'hFF, 1, 1'b0);
    // Empty mask goes straight to HOLD
    run_scan(64'h0, 64'hFFFF, 0, 1'b0);
    // Long HOLD with ignored start pulses and en_mask churn
    run_scan(64'h0000_0F0F_0000_3C01, {$urandom, $urandom}, 10, 1'b1);

    // Reset asserted while sel is on channel 3
    @(negedge clk);
    pat = 64'hFF; en_mask = 64'hFF; start = 1'b1;
    for (int t = 0; t <= 3 * (SETTLE + 1); t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_sel", 64'(sel), 64'd3);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 3 * K; t++) begin
      @(negedge clk);
      if (snap_valid !== 1'b0 || busy !== 1'b0) begin
        chk("post_reset_valid", 64'(snap_valid), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
      end
    end
    chk("post_reset_valid_end", 64'(snap_valid), 64'd0);
    run_scan(64'hF0, 64'h5A, 1, 1'b0);

    // All channels, only the ends set
    run_scan('1, 64'h8000_0000_0000_0001, 3, 1'b0);

    // Randomized scans
    for (int r = 0; r < 4; r++) begin
      logic [K-1:0] m, p;
      m = {$urandom, $urandom} & {$urandom, $urandom};
      p = {$urandom, $urandom};
      run_scan(m, p, int'($urandom_range(0, 4)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
